// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM, redirects through a
// loadable branch-target LUT, and runs the start/done handshake with a RUN-cycle counter.
module fetch_unit #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned INSTR_W   = 9,
  parameter int unsigned LUT_IDX_W = 5,
  parameter logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(9'h1FF),
  parameter logic [INSTR_W-1:0] NOP_WORD  = INSTR_W'(9'h1E0),
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 branch,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  input  logic [INSTR_W-1:0]   instr_in,
  output logic [PC_W-1:0]      pc,
  output logic [INSTR_W-1:0]   instr_out,
  output logic                 instr_valid,
  output logic                 done,
  output logic [CNT_W-1:0]     cycle_count,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata
);

  localparam int unsigned LUT_DEPTH = 2 ** LUT_IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [PC_W-1:0]  lut_q [LUT_DEPTH];

  // Next PC while running: LUT redirect on a taken branch, else sequential with natural wrap.
  assign pc_d  = branch ? lut_q[branch_idx] : pc_q + PC_W'(1);
  assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < int'(LUT_DEPTH); i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE, HALT: begin
          // LUT is only writable while stopped; a write on the start edge is visible from cycle 0.
          if (lut_we) begin
            lut_q[lut_waddr] <= lut_wdata;
          end
          if (start) begin
            state_q <= RUN;
            pc_q    <= '0;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          cnt_q <= cnt_d;
          if (instr_in == HALT_WORD) begin
            state_q <= HALT;
          end else begin
            pc_q <= pc_d;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign cycle_count = cnt_q;
  assign instr_valid = (state_q == RUN);
  assign done        = (state_q == HALT);
  assign instr_out   = (state_q == RUN) ? instr_in : NOP_WORD;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed and random programs checked against an
// architectural trace built by executing the ROM image with a model branch table.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;

  logic        start;
  logic        branch;
  logic [4:0]  branch_idx;
  logic [8:0]  instr_in;
  logic [9:0]  pc;
  logic [8:0]  instr_out;
  logic        instr_valid;
  logic        done;
  logic [15:0] cycle_count;
  logic        lut_we;
  logic [4:0]  lut_waddr;
  logic [9:0]  lut_wdata;

  logic        start_s;
  logic [8:0]  instr_in_s;
  logic [2:0]  pc_s;
  logic [8:0]  instr_out_s;
  logic        instr_valid_s;
  logic        done_s;
  logic [2:0]  cycle_count_s;

  logic [8:0]  rom   [1024];
  logic [8:0]  rom_s [8];
  logic [9:0]  m_lut [32];

  int          total;
  int          bad;
  int unsigned tr [$];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .branch(branch), .branch_idx(branch_idx),
    .instr_in(instr_in), .pc(pc), .instr_out(instr_out), .instr_valid(instr_valid),
    .done(done), .cycle_count(cycle_count), .lut_we(lut_we), .lut_waddr(lut_waddr),
    .lut_wdata(lut_wdata)
  );

  fetch_unit #(.PC_W(3), .CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .branch(1'b0), .branch_idx(5'd0),
    .instr_in(instr_in_s), .pc(pc_s), .instr_out(instr_out_s), .instr_valid(instr_valid_s),
    .done(done_s), .cycle_count(cycle_count_s), .lut_we(1'b0), .lut_waddr(5'd0),
    .lut_wdata(3'd0)
  );

  // Bench plays the ROM and the decoder: opcode 1010 is a branch whose index is the low 5 bits.
  always_comb begin
    instr_in   = rom[pc];
    branch     = (instr_in[8:5] == 4'b1010);
    branch_idx = instr_in[4:0];
    instr_in_s = rom_s[pc_s];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, 32'(pc), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_iout"}, 32'(instr_out), 32'h1E0);
    chk({tag, "_cnt"}, 32'(cycle_count), 32'd0);
  endtask

  task automatic lut_write(input int unsigned idx, input int unsigned data);
    lut_we    = 1'b1;
    lut_waddr = 5'(idx);
    lut_wdata = 10'(data);
    m_lut[idx] = 10'(data);
    @(negedge clk);
    lut_we = 1'b0;
  endtask

  // Entered and left on a falling edge. Starts a run (optionally writing the LUT on the
  // start edge), follows the expected pc trace, then checks HALT or resets a runaway program.
  task automatic run_check(input string tag, input int budget, input bit wr,
                           input int unsigned waddr, input int unsigned wdata, input bit hammer);
    int unsigned p;
    bit          halted;
    logic [8:0]  w;
    if (wr) m_lut[waddr] = 10'(wdata);
    tr.delete();
    p = 0;
    halted = 0;
    while (tr.size() < budget) begin
      tr.push_back(p);
      w = rom[p];
      if (w == 9'h1FF) begin
        halted = 1;
        break;
      end
      if (w[8:5] == 4'b1010) p = m_lut[w[4:0]];
      else p = (p + 1) % 1024;
    end
    start     = 1'b1;
    lut_we    = wr;
    lut_waddr = 5'(waddr);
    lut_wdata = 10'(wdata);
    @(negedge clk);
    start  = 1'b0;
    lut_we = 1'b0;
    for (int k = 0; k < tr.size(); k++) begin
      chk({tag, "_pc"}, 32'(pc), tr[k]);
      chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_iout"}, 32'(instr_out), 32'(rom[tr[k]]));
      chk({tag, "_cnt"}, 32'(cycle_count), 32'(k));
      // Restart requests and LUT writes while running must both be ignored.
      start = 1'($urandom_range(0, 1));
      if (hammer) begin
        lut_we    = 1'b1;
        lut_waddr = 5'd3;
        lut_wdata = 10'd99;
      end else begin
        lut_we    = 1'($urandom_range(0, 1));
        lut_waddr = 5'($urandom);
        lut_wdata = 10'($urandom);
      end
      @(negedge clk);
    end
    start  = 1'b0;
    lut_we = 1'b0;
    if (halted) begin
      chk({tag, "_hdone"}, 32'(done), 32'd1);
      chk({tag, "_hpc"}, 32'(pc), tr[tr.size() - 1]);
      chk({tag, "_hcnt"}, 32'(cycle_count), 32'(tr.size()));
      chk({tag, "_hvalid"}, 32'(instr_valid), 32'd0);
      chk({tag, "_hiout"}, 32'(instr_out), 32'h1E0);
    end else begin
      #2 rst_n = 1'b0;
      #1 chk_reset({tag, "_rst"});
      for (int i = 0; i < 32; i++) m_lut[i] = '0;
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    start     = 1'b0;
    start_s   = 1'b0;
    lut_we    = 1'b0;
    lut_waddr = '0;
    lut_wdata = '0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
    for (int i = 0; i < 8; i++) rom_s[i] = 9'h000;
    for (int i = 0; i < 32; i++) m_lut[i] = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_reset("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Narrow instance: pc wraps 6,7,0 and the 3-bit counter saturates at 7.
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      chk("wrap_pc", 32'(pc_s), 32'(k % 8));
      chk("sat_cnt", 32'(cycle_count_s), 32'((k < 7) ? k : 7));
      @(negedge clk);
    end

    rom[5] = 9'h1FF;
    run_check("seq", 100, 1'b0, 0, 0, 1'b0);

    lut_write(3, 40);
    rom[2]  = {4'b1010, 5'd3};
    rom[40] = 9'h1FF;
    run_check("br", 100, 1'b0, 0, 0, 1'b0);
    run_check("br_blk", 100, 1'b0, 0, 0, 1'b1);

    rom[0]   = {4'b1010, 5'd7};
    rom[100] = 9'h1FF;
    run_check("wr_start", 100, 1'b1, 7, 100, 1'b0);

    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < 1024; i++) begin
        int unsigned r;
        r = $urandom_range(0, 99);
        if (r < 4) rom[i] = 9'h1FF;
        else if (r < 24) rom[i] = {4'b1010, 5'($urandom)};
        else rom[i] = {1'b0, 8'($urandom)};
      end
      for (int j = 0; j < 4; j++) lut_write($urandom_range(0, 31), $urandom_range(0, 1023));
      run_check("rnd", 60, 1'($urandom_range(0, 1)), $urandom_range(0, 31),
                $urandom_range(0, 1023), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
